// File: rtl/box_pkg.sv
// Shared types and constants for the bounding-box record reader:
// record layout, word offsets and FSM state encoding.
package box_pkg;

    localparam int REC_WORDS = 8;

    typedef logic [2:0] word_idx_t;

    localparam word_idx_t W_ID   = 3'd0;
    localparam word_idx_t W_CONF = 3'd1;
    localparam word_idx_t W_X1   = 3'd2;
    localparam word_idx_t W_Y1   = 3'd3;
    localparam word_idx_t W_X2   = 3'd4;
    localparam word_idx_t W_Y2   = 3'd5;
    localparam word_idx_t W_CLS  = 3'd6;
    localparam word_idx_t W_FLAG = 3'd7;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] conf;
        logic [31:0] x1;
        logic [31:0] y1;
        logic [31:0] x2;
        logic [31:0] y2;
        logic [31:0] cls;
        logic [31:0] flag;
    } box_rec_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT,
        DONE
    } state_t;

    // Returns r with the field at word offset w replaced by d.
    function automatic box_rec_t set_word(input box_rec_t r, input word_idx_t w,
                                          input logic [31:0] d);
        box_rec_t n;
        n = r;
        case (w)
            W_ID:    n.id   = d;
            W_CONF:  n.conf = d;
            W_X1:    n.x1   = d;
            W_Y1:    n.y1   = d;
            W_X2:    n.x2   = d;
            W_Y2:    n.y2   = d;
            W_CLS:   n.cls  = d;
            W_FLAG:  n.flag = d;
            default: n      = r;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/box_record_reader.sv
// Reads fixed 8-word box records from the data SRAM and presents each
// complete record as one wide valid/ready transfer.
module box_record_reader
    import box_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int REC_WORDS = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        num_rec,
    output logic              busy,
    output logic              done,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [31:0]       sram_q,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [31:0]       rec_id,
    output logic [31:0]       rec_conf,
    output logic [31:0]       rec_x1,
    output logic [31:0]       rec_y1,
    output logic [31:0]       rec_x2,
    output logic [31:0]       rec_y2,
    output logic [31:0]       rec_cls,
    output logic [31:0]       rec_flag
);

    state_t    state, state_nx;
    logic [7:0] num_lat;
    logic [7:0] rec_idx;
    word_idx_t wcnt;
    word_idx_t cap_w;
    logic      cap_en;
    box_rec_t  rec_q;
    logic      more;

    assign more = ({1'b0, rec_idx} + 9'd1) < {1'b0, num_lat};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            num_lat <= '0;
            rec_idx <= '0;
            wcnt    <= '0;
            cap_w   <= '0;
            cap_en  <= 1'b0;
            rec_q   <= '0;
        end else begin
            state <= state_nx;
            // SRAM data lags its address by one cycle, so capture trails issue.
            cap_en <= (state == ISSUE);
            cap_w  <= wcnt;
            if (cap_en)
                rec_q <= set_word(rec_q, cap_w, sram_q);
            case (state)
                IDLE: begin
                    if (start) begin
                        num_lat <= num_rec;
                        rec_idx <= '0;
                        wcnt    <= '0;
                    end
                end
                ISSUE:   wcnt <= wcnt + 3'd1;
                OUT:     if (rec_ready) rec_idx <= rec_idx + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_rec == 8'd0) ? DONE : ISSUE;
            ISSUE:   if (wcnt == word_idx_t'(REC_WORDS - 1)) state_nx = DRAIN;
            DRAIN:   state_nx = OUT;
            OUT:     if (rec_ready) state_nx = more ? ISSUE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        sram_cen  = (state != ISSUE);
        sram_wen  = 1'b1;
        rec_valid = (state == OUT);
        sram_a    = '0;
        if (state == ISSUE)
            sram_a = ADDR_W'(BASE_ADDR) + ADDR_W'({rec_idx, wcnt});
    end

    assign rec_id   = rec_q.id;
    assign rec_conf = rec_q.conf;
    assign rec_x1   = rec_q.x1;
    assign rec_y1   = rec_q.y1;
    assign rec_x2   = rec_q.x2;
    assign rec_y2   = rec_q.y2;
    assign rec_cls  = rec_q.cls;
    assign rec_flag = rec_q.flag;

endmodule

// File: tb/tb_box_record_reader.sv
// Directed bench for box_record_reader: two instances (base 0 and base 1020)
// share a behavioural 32x1024 SRAM with one read port each.
module tb_box_record_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  num0 = '0, num1 = '0;
    logic        ready0 = 1'b0, ready1 = 1'b0;

    logic        busy0, done0, cen0, wen0, valid0;
    logic        busy1, done1, cen1, wen1, valid1;
    logic [9:0]  a0, a1;
    logic [31:0] q0, q1;
    logic [31:0] id0, conf0, x10, y10, x20, y20, cls0, flag0;
    logic [31:0] id1, conf1, x11, y11, x21, y21, cls1, flag1;

    logic [31:0] mem [1024];
    logic        sram_rstn;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;
    assign sram_rstn = ~RST;

    always @(posedge CLK) begin
        if (!sram_rstn) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            if (!cen0) q0 <= mem[a0];
            if (!cen1) q1 <= mem[a1];
        end
    end

    box_record_reader u0 (
        .CLK(CLK), .RST(RST), .start(start0), .num_rec(num0),
        .busy(busy0), .done(done0), .sram_cen(cen0), .sram_wen(wen0),
        .sram_a(a0), .sram_q(q0), .rec_valid(valid0), .rec_ready(ready0),
        .rec_id(id0), .rec_conf(conf0), .rec_x1(x10), .rec_y1(y10),
        .rec_x2(x20), .rec_y2(y20), .rec_cls(cls0), .rec_flag(flag0)
    );

    box_record_reader #(.BASE_ADDR(1020)) u1 (
        .CLK(CLK), .RST(RST), .start(start1), .num_rec(num1),
        .busy(busy1), .done(done1), .sram_cen(cen1), .sram_wen(wen1),
        .sram_a(a1), .sram_q(q1), .rec_valid(valid1), .rec_ready(ready1),
        .rec_id(id1), .rec_conf(conf1), .rec_x1(x11), .rec_y1(y11),
        .rec_x2(x21), .rec_y2(y21), .rec_cls(cls1), .rec_flag(flag1)
    );

    // Preloaded contents: record 0 and 16 fixed, other records patterned,
    // addresses above record 16 tagged with their own address.
    function automatic logic [31:0] mem_word(input int addr);
        int r, w;
        r = addr / 8;
        w = addr % 8;
        if (addr >= 136) return 32'hE000_0000 | addr;
        if (r == 0) begin
            case (w)
                1: return 32'h3F40_0000;
                2: return 32'h4296_0000;
                3: return 32'h4270_0000;
                4: return 32'h42E6_0000;
                5: return 32'h42BE_0000;
                7: return 32'h0000_0001;
                default: return 32'h0;
            endcase
        end
        if (r == 16) begin
            case (w)
                0: return 32'd16;
                1: return 32'h3F59_9999;
                2: return 32'h42BE_0000;
                6: return 32'd2;
                default: ;
            endcase
        end
        if (w == 0) return r;
        return 32'hB000_0000 | (r << 8) | w;
    endfunction

    function automatic logic [31:0] fld0(input int w);
        case (w)
            0: return id0;   1: return conf0; 2: return x10;  3: return y10;
            4: return x20;   5: return y20;   6: return cls0; default: return flag0;
        endcase
    endfunction

    function automatic logic [31:0] fld1(input int w);
        case (w)
            0: return id1;   1: return conf1; 2: return x11;  3: return y11;
            4: return x21;   5: return y21;   6: return cls1; default: return flag1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, ".busy"}, {31'd0, busy0}, 32'd0);
        chk({tag, ".done"}, {31'd0, done0}, 32'd0);
        chk({tag, ".cen"}, {31'd0, cen0}, 32'd1);
        chk({tag, ".wen"}, {31'd0, wen0}, 32'd1);
        chk({tag, ".a"}, {22'd0, a0}, 32'd0);
        chk({tag, ".valid"}, {31'd0, valid0}, 32'd0);
        for (int w = 0; w < 8; w++) chk($sformatf("%s.f%0d", tag, w), fld0(w), 32'd0);
    endtask

    // Walks one record on u0 from its first ISSUE cycle through OUT (ready high).
    task automatic run_rec0(input string tag, input int r);
        for (int w = 0; w < 8; w++) begin
            chk($sformatf("%s.r%0d.cen%0d", tag, r, w), {31'd0, cen0}, 32'd0);
            chk($sformatf("%s.r%0d.a%0d", tag, r, w), {22'd0, a0}, r * 8 + w);
            tick();
        end
        chk($sformatf("%s.r%0d.drain_cen", tag, r), {31'd0, cen0}, 32'd1);
        chk($sformatf("%s.r%0d.drain_valid", tag, r), {31'd0, valid0}, 32'd0);
        tick();
        chk($sformatf("%s.r%0d.valid", tag, r), {31'd0, valid0}, 32'd1);
        for (int w = 0; w < 8; w++)
            chk($sformatf("%s.r%0d.f%0d", tag, r, w), fld0(w), mem_word(r * 8 + w));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = mem_word(i);

        // Reset state
        repeat (3) tick();
        chk_reset0("rst");
        chk("rst.u1cen", {31'd0, cen1}, 32'd1);
        RST = 1'b0;
        tick();

        // Single record, latency 10, done in cycle 11
        num0 = 8'd1; ready0 = 1'b1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("single.busy", {31'd0, busy0}, 32'd1);
        run_rec0("single", 0);
        chk("single.done", {31'd0, done0}, 32'd1);
        chk("single.valid_off", {31'd0, valid0}, 32'd0);
        tick();
        chk("single.busy_off", {31'd0, busy0}, 32'd0);
        chk("single.done_off", {31'd0, done0}, 32'd0);
        tick();

        // Full pass of 17 records back to back
        num0 = 8'd17; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        num0 = 8'd3;
        for (int r = 0; r < 17; r++) run_rec0("full", r);
        chk("full.done", {31'd0, done0}, 32'd1);
        chk("full.cen", {31'd0, cen0}, 32'd1);
        tick();
        chk("full.busy_off", {31'd0, busy0}, 32'd0);
        tick();

        // Backpressure: two records, ready low for 20 cycles
        num0 = 8'd2; ready0 = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (9) tick();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("bp.valid%0d", c), {31'd0, valid0}, 32'd1);
            chk($sformatf("bp.cen%0d", c), {31'd0, cen0}, 32'd1);
            chk($sformatf("bp.conf%0d", c), conf0, 32'h3F40_0000);
            chk($sformatf("bp.flag%0d", c), flag0, 32'd1);
            start0 = (c == 5);
            tick();
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        chk("bp.hold_valid", {31'd0, valid0}, 32'd1);
        chk("bp.hold_x1", x10, 32'h4296_0000);
        tick();
        run_rec0("bp", 1);
        chk("bp.done", {31'd0, done0}, 32'd1);
        tick();
        tick();

        // Zero records: no SRAM access, done in cycle 1
        num0 = 8'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("zero.done", {31'd0, done0}, 32'd1);
        chk("zero.busy", {31'd0, busy0}, 32'd1);
        chk("zero.cen", {31'd0, cen0}, 32'd1);
        chk("zero.valid", {31'd0, valid0}, 32'd0);
        tick();
        chk("zero.done_off", {31'd0, done0}, 32'd0);
        chk("zero.busy_off", {31'd0, busy0}, 32'd0);
        chk("zero.cen2", {31'd0, cen0}, 32'd1);
        chk("zero.valid2", {31'd0, valid0}, 32'd0);
        tick();

        // Address wrap on the base-1020 instance
        num1 = 8'd1; ready1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int w = 0; w < 8; w++) begin
            chk($sformatf("wrap.cen%0d", w), {31'd0, cen1}, 32'd0);
            chk($sformatf("wrap.a%0d", w), {22'd0, a1}, (1020 + w) % 1024);
            tick();
        end
        chk("wrap.drain_cen", {31'd0, cen1}, 32'd1);
        tick();
        chk("wrap.valid", {31'd0, valid1}, 32'd1);
        for (int w = 0; w < 8; w++)
            chk($sformatf("wrap.f%0d", w), fld1(w), mem_word((1020 + w) % 1024));
        tick();
        chk("wrap.done", {31'd0, done1}, 32'd1);
        tick();
        tick();

        // Reset in the fifth ISSUE cycle, then restart from record 0
        num0 = 8'd3; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        chk("rstmid.cen_before", {31'd0, cen0}, 32'd0);
        chk("rstmid.a_before", {22'd0, a0}, 32'd4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_reset0("rstmid");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rstmid.idle_done%0d", c), {31'd0, done0}, 32'd0);
            chk($sformatf("rstmid.idle_cen%0d", c), {31'd0, cen0}, 32'd1);
            tick();
        end
        num0 = 8'd1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        run_rec0("restart", 0);
        chk("restart.done", {31'd0, done0}, 32'd1);
        tick();
        chk("restart.busy_off", {31'd0, busy0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
